// File: rtl/receiver.sv
// UART 8N1 receiver: 2-FF synchronised input, mid-bit sampling, one-cycle rx_valid / framing_error strobes.
// Latency: rx_valid rises HALF_COUNT + 9*BAUD_COUNT + 3 cycles after the rxd falling edge.
// No backpressure: rx_data is held only until the next good frame overwrites it.
module receiver #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_COUNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        rxd_s;
    logic [15:0] baudcnt_q, baudcnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        ferr_q, ferr_d;

    assign rxd_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            baudcnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            baudcnt_q  <= baudcnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baudcnt_d  = baudcnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d   = S_START;
                    baudcnt_d = 16'd0;
                end
            end
            S_START: begin
                // A start bit that is gone by mid-bit was a glitch: drop it silently.
                if (baudcnt_q == HALF_LAST) begin
                    baudcnt_d = 16'd0;
                    if (!rxd_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baudcnt_q == BAUD_LAST) begin
                    baudcnt_d = 16'd0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baudcnt_q == BAUD_LAST) begin
                    baudcnt_d = 16'd0;
                    if (rxd_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    baudcnt_d = baudcnt_q + 16'd1;
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break cannot retrigger frames.
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = ferr_q;
    assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver.sv
// Bench for the UART receiver: table of frames plus hand-written corner sequences,
// with a byte scoreboard popped on every rx_valid strobe.
module tb_receiver;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 62500;
    localparam int BIT       = 16;
    localparam int HALF      = 8;
    localparam int LATENCY   = HALF + 9 * BIT + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       rx_busy;

    receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int last_vld_cyc = 0;
    logic prev_vld = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard side: every strobe is checked for width, exclusivity and byte order.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (rx_valid === 1'b1) begin
                vld_cnt++;
                last_vld_cyc = cyc;
                chk("valid_pulse_width", int'(prev_vld), 0);
                chk("valid_ferr_exclusive", int'(framing_error), 0);
                chk("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("rx_data_order", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (framing_error === 1'b1) begin
                ferr_cnt++;
                chk("ferr_pulse_width", int'(prev_ferr), 0);
            end
        end
        prev_vld  = rx_valid;
        prev_ferr = framing_error;
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        ticks(BIT);
    endtask

    task automatic send_bits(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        send_bits(d);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int   v0, f0, c0, lat;
    logic [7:0] held;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 20, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 5, 8'h55};
        vecs[4] = '{8'h80, 1'b0, 2 * BIT, 8'h55};
        vecs[5] = '{8'h01, 1'b1, 10, 8'h01};

        rxd   = 1'b1;
        reset = 1'b1;
        ticks(3);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_ferr", int'(framing_error), 0);
        chk("reset_busy", int'(rx_busy), 0);
        reset = 1'b0;
        ticks(5);

        // Falling edge to rx_valid latency.
        v0 = vld_cnt;
        c0 = cyc;
        send_frame(8'hC3, 1'b1);
        ticks(10);
        chk("latency_frame_count", vld_cnt - v0, 1);
        lat = last_vld_cyc - c0;
        checks++;
        if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
            errors++;
            $display("FAIL latency: actual %0d cycles required %0d +/-1", lat, LATENCY);
        end

        for (int i = 0; i < 6; i++) begin
            v0 = vld_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            chk("vec_busy_after_stop", int'(rx_busy), int'(!vecs[i].stop));
            rxd = 1'b1;
            ticks(vecs[i].gap);
            chk("vec_valid_count", vld_cnt - v0, int'(vecs[i].stop));
            chk("vec_ferr_count", ferr_cnt - f0, int'(!vecs[i].stop));
            chk("vec_rx_data", int'(rx_data), int'(vecs[i].exp_data));
        end
        ticks(4);
        chk("vec_busy_idle", int'(rx_busy), 0);

        // Short low glitch: START must abort back to IDLE.
        v0 = vld_cnt;
        f0 = ferr_cnt;
        rxd = 1'b0;
        ticks(HALF - 4);
        chk("glitch_busy_in_start", int'(rx_busy), 1);
        rxd = 1'b1;
        ticks(3 * BIT);
        chk("glitch_valid_count", vld_cnt - v0, 0);
        chk("glitch_ferr_count", ferr_cnt - f0, 0);
        chk("glitch_busy_after", int'(rx_busy), 0);

        // Bad stop followed by a held-low break line.
        held = rx_data;
        v0 = vld_cnt;
        f0 = ferr_cnt;
        send_bits(8'h3C);
        rxd = 1'b0;
        ticks(300);
        chk("break_ferr_count", ferr_cnt - f0, 1);
        chk("break_valid_count", vld_cnt - v0, 0);
        chk("break_rx_data_held", int'(rx_data), int'(held));
        chk("break_busy_while_low", int'(rx_busy), 1);
        rxd = 1'b1;
        ticks(2 * BIT);
        chk("break_busy_released", int'(rx_busy), 0);
        send_frame(8'h81, 1'b1);
        ticks(BIT);
        chk("after_break_valid_count", vld_cnt - v0, 1);
        chk("after_break_rx_data", int'(rx_data), 8'h81);

        // One-cycle reset in the middle of data bit 4 of 0xF3.
        v0 = vld_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rxd = 1'b1;
        ticks(HALF);
        reset = 1'b1;
        ticks(1);
        chk("midreset_rx_data", int'(rx_data), 0);
        chk("midreset_rx_valid", int'(rx_valid), 0);
        chk("midreset_ferr", int'(framing_error), 0);
        chk("midreset_busy", int'(rx_busy), 0);
        reset = 1'b0;
        ticks(4 * BIT);
        chk("midreset_no_valid", vld_cnt - v0, 0);
        chk("midreset_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h5A, 1'b1);
        ticks(BIT);
        chk("midreset_next_count", vld_cnt - v0, 1);
        chk("midreset_next_data", int'(rx_data), 8'h5A);

        // Continuous transmitter-style stream of every byte value.
        v0 = vld_cnt;
        f0 = ferr_cnt;
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        rxd = 1'b1;
        ticks(2 * BIT);
        chk("loopback_valid_count", vld_cnt - v0, 256);
        chk("loopback_ferr_count", ferr_cnt - f0, 0);
        chk("loopback_last_data", int'(rx_data), 8'hFF);
        chk("scoreboard_drained", int'(exp_q.size()), 0);
        chk("final_busy", int'(rx_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
